// File: rtl/whackamole_round_ctrl.sv
// Whackamole game sequencer: LFSR mole picker, GAP/SHOW timing on the tick
// strobe, hit/wrong-whack/timeout scoring, level progression and game over.
module whackamole_round_ctrl #(
  parameter logic [7:0] LFSR_SEED   = 8'hB8,
  parameter int         BASE_WINDOW = 16,
  parameter int         GAP_TICKS   = 4,
  parameter int         LEVEL_STEP  = 10,
  parameter int         MAX_LEVEL   = 7,
  parameter int         MAX_MISSES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic [7:0] score,
  output logic [2:0] level,
  output logic [1:0] misses,
  output logic       game_over,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  localparam logic [7:0] GAP_LOAD   = 8'(GAP_TICKS);
  localparam logic [7:0] PTS_LAST   = 8'(LEVEL_STEP - 1);
  localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [1:0] MISS_LIMIT = 2'(MAX_MISSES);

  logic [1:0] state, state_d;
  logic [7:0] lfsr;
  logic [7:0] sw_q;
  logic [7:0] gap_cnt, gap_cnt_d;
  logic [7:0] win_cnt, win_cnt_d;
  logic [7:0] pts, pts_d;
  logic [7:0] led_d, score_d;
  logic [2:0] level_d;
  logic [1:0] misses_d;
  logic [7:0] edges;
  logic [7:0] win_load;
  logic       hit, wrong, timeout;

  assign edges    = sw ^ sw_q;
  assign win_load = 8'(BASE_WINDOW - 2 * (int'(level) - 1));

  // led holds the one-hot mole while in SHOW, so it doubles as the hit mask.
  assign hit     = (state == SHOW) && (|(edges & led));
  assign wrong   = (state == SHOW) && (|edges) && !hit;
  assign timeout = (state == SHOW) && tick && (win_cnt == 8'd1);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d   = state;
    gap_cnt_d = gap_cnt;
    win_cnt_d = win_cnt;
    pts_d     = pts;
    led_d     = led;
    score_d   = score;
    level_d   = level;
    misses_d  = misses;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          score_d   = 8'd0;
          misses_d  = 2'd0;
          pts_d     = 8'd0;
          level_d   = 3'd1;
          led_d     = 8'd0;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
        end
      end

      GAP: begin
        if (tick) begin
          if (gap_cnt == 8'd1) begin
            led_d     = 8'd1 << lfsr[2:0];
            win_cnt_d = win_load;
            state_d   = SHOW;
          end else begin
            gap_cnt_d = gap_cnt - 8'd1;
          end
        end
      end

      SHOW: begin
        if (tick) win_cnt_d = win_cnt - 8'd1;
        if (hit) begin
          if (score != 8'hFF) score_d = score + 8'd1;
          if (pts == PTS_LAST) begin
            pts_d = 8'd0;
            if (level < LEVEL_MAX) level_d = level + 3'd1;
          end else begin
            pts_d = pts + 8'd1;
          end
          led_d     = 8'd0;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
        end else if (wrong || timeout) begin
          // A wrong whack coinciding with the timeout is still a single miss.
          misses_d = misses + 2'd1;
          if (misses_d == MISS_LIMIT) begin
            led_d   = 8'd0;
            state_d = OVER;
          end else if (timeout) begin
            led_d     = 8'd0;
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      sw_q      <= sw;  // track current switches so no edge appears after reset
      gap_cnt   <= 8'd0;
      win_cnt   <= 8'd0;
      pts       <= 8'd0;
      led       <= 8'd0;
      score     <= 8'd0;
      level     <= 3'd1;
      misses    <= 2'd0;
      game_over <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      sw_q      <= sw;
      gap_cnt   <= gap_cnt_d;
      win_cnt   <= win_cnt_d;
      pts       <= pts_d;
      led       <= led_d;
      score     <= score_d;
      level     <= level_d;
      misses    <= misses_d;
      game_over <= (state_d == OVER);
      busy      <= (state_d == GAP) || (state_d == SHOW);
    end
  end

endmodule

// File: tb/tb_whackamole_round_ctrl.sv
// Scoreboard bench: stimulus pushes the expected output tuple and cycle for
// every output change; a negedge monitor pops and compares on each change.
module tb_whackamole_round_ctrl;

  localparam logic [7:0] SEED = 8'hB8;
  localparam int BASE = 16;
  localparam int GAPT = 4;
  localparam int STEP = 10;
  localparam int MAXL = 7;
  localparam int MAXM = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sw    = 8'h5A;
  logic [7:0] led, score;
  logic [2:0] level;
  logic [1:0] misses;
  logic       game_over, busy;

  whackamole_round_ctrl #(
    .LFSR_SEED(SEED), .BASE_WINDOW(BASE), .GAP_TICKS(GAPT),
    .LEVEL_STEP(STEP), .MAX_LEVEL(MAXL), .MAX_MISSES(MAXM)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .sw(sw),
    .led(led), .score(score), .level(level), .misses(misses),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [7:0] score;
    logic [2:0] level;
    logic [1:0] misses;
    logic       game_over;
    logic       busy;
  } obs_t;

  obs_t  sb_v[$];
  int    sb_cyc[$];
  string sb_name[$];

  int cyc = 0;
  int applied = 0;
  int miscompares = 0;
  logic [7:0] m_lfsr;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, advancing every non-reset cycle.
  always @(posedge clk)
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  // Monitor
  obs_t prev = 'x;
  always @(negedge clk) begin
    obs_t  cur, ev;
    int    ec;
    string en;
    cur = {led, score, level, misses, game_over, busy};
    if (cur !== prev) begin
      applied++;
      if (sb_v.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: got led=%h score=%0d level=%0d misses=%0d game_over=%0b busy=%0b @%0d, required no change",
                 cur.led, cur.score, cur.level, cur.misses, cur.game_over, cur.busy, cyc);
      end else begin
        ev = sb_v.pop_front();
        ec = sb_cyc.pop_front();
        en = sb_name.pop_front();
        if (cur !== ev || cyc != ec) begin
          miscompares++;
          $display("FAIL %s: got led=%h score=%0d level=%0d misses=%0d game_over=%0b busy=%0b @%0d, required led=%h score=%0d level=%0d misses=%0d game_over=%0b busy=%0b @%0d",
                   en, cur.led, cur.score, cur.level, cur.misses, cur.game_over, cur.busy, cyc,
                   ev.led, ev.score, ev.level, ev.misses, ev.game_over, ev.busy, ec);
        end
      end
      prev = cur;
    end
  end

  // Game model
  logic [7:0] e_led, e_score;
  logic [2:0] e_level;
  logic [1:0] e_misses;
  logic       e_go, e_busy;
  int         e_pts, e_win;

  task automatic reset_model();
    e_led = 8'd0; e_score = 8'd0; e_level = 3'd1; e_misses = 2'd0;
    e_go = 1'b0; e_busy = 1'b0; e_pts = 0; e_win = 0;
  endtask

  // Expected change is visible one cycle after the current drive cycle.
  task automatic expect_now(input string name);
    sb_v.push_back({e_led, e_score, e_level, e_misses, e_go, e_busy});
    sb_cyc.push_back(cyc + 1);
    sb_name.push_back(name);
  endtask

  task automatic drive(input logic t, input logic [7:0] s, input logic st);
    @(negedge clk);
    tick = t; sw = s; start = st;
  endtask

  task automatic start_game(input string name);
    drive(1'b0, sw, 1'b1);
    e_score = 8'd0; e_misses = 2'd0; e_pts = 0; e_level = 3'd1;
    e_go = 1'b0; e_busy = 1'b1; e_led = 8'd0;
    expect_now(name);
  endtask

  task automatic gap_phase(input string name);
    for (int i = 1; i <= GAPT; i++) begin
      drive(1'b0, sw, 1'b0);
      drive(1'b1, sw, 1'b0);
      if (i == GAPT) begin
        e_led = 8'd1 << m_lfsr[2:0];
        e_win = BASE - 2 * (int'(e_level) - 1);
        expect_now(name);
      end
    end
  endtask

  task automatic score_hit();
    if (e_score != 8'hFF) e_score = e_score + 8'd1;
    e_pts++;
    if (e_pts == STEP) begin
      e_pts = 0;
      if (int'(e_level) < MAXL) e_level = e_level + 3'd1;
    end
    e_led = 8'd0;
  endtask

  task automatic take_miss();
    e_misses = e_misses + 2'd1;
    if (int'(e_misses) == MAXM) begin
      e_led = 8'd0; e_go = 1'b1; e_busy = 1'b0;
    end
  endtask

  task automatic hit(input string name);
    drive(1'b0, sw ^ e_led, 1'b0);
    score_hit();
    expect_now(name);
  endtask

  task automatic wrong_whack(input string name);
    logic [7:0] m;
    int n;
    m = 8'd0; n = 0;
    for (int b = 0; b < 8; b++)
      if (!e_led[b] && n < 2) begin m[b] = 1'b1; n++; end
    drive(1'b0, sw ^ m, 1'b0);
    take_miss();
    expect_now(name);
  endtask

  task automatic timeout_run(input string name);
    for (int i = 1; i <= e_win; i++) begin
      drive(1'b0, sw, 1'b0);
      drive(1'b1, sw, 1'b0);
      if (i == e_win) begin
        e_led = 8'd0;
        take_miss();
        expect_now(name);
      end
    end
  endtask

  task automatic late_hit(input string name);
    for (int i = 1; i <= e_win; i++) begin
      drive(1'b0, sw, 1'b0);
      if (i < e_win) drive(1'b1, sw, 1'b0);
      else begin
        drive(1'b1, sw ^ e_led, 1'b0);
        score_hit();
        expect_now(name);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    reset_model();
    expect_now("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) drive(1'b0, 8'h5A, 1'b0);

    start_game("start");
    gap_phase("first_mole");
    hit("hit_first");
    gap_phase("mole_after_hit");
    wrong_whack("wrong_two_bits");
    timeout_run("timeout_16");
    gap_phase("mole_g1");
    timeout_run("timeout_to_over");

    // Switch edges and idle cycles in OVER must not change anything.
    drive(1'b0, sw ^ 8'h01, 1'b0);
    drive(1'b1, sw ^ 8'h80, 1'b0);
    drive(1'b0, sw, 1'b0);

    start_game("restart_from_over");
    for (int i = 0; i < 3; i++) begin
      gap_phase("mole_g2");
      timeout_run("timeout_g2");
    end

    start_game("restart_for_levels");
    for (int i = 1; i <= 60; i++) begin
      gap_phase("mole_lv");
      hit("hit_lv");
      if (i == 10) begin
        gap_phase("mole_level2");
        timeout_run("timeout_window_14");
      end
    end
    gap_phase("mole_level7");
    timeout_run("timeout_window_4");
    for (int i = 0; i < 12; i++) begin
      gap_phase("mole_sat");
      hit("hit_level_sat");
    end
    gap_phase("mole_late");
    late_hit("hit_on_final_tick");

    gap_phase("mole_before_rst");
    drive(1'b0, sw, 1'b0);
    rst = 1'b1;
    reset_model();
    expect_now("rst_mid_show");
    drive(1'b0, sw, 1'b0);
    rst = 1'b0;
    repeat (6) drive(1'b0, sw, 1'b0);

    @(negedge clk);
    #1;
    while (sb_v.size() > 0) begin
      obs_t  ev;
      int    ec;
      string en;
      ev = sb_v.pop_front();
      ec = sb_cyc.pop_front();
      en = sb_name.pop_front();
      applied++;
      miscompares++;
      $display("FAIL %s: got no output change, required led=%h score=%0d level=%0d misses=%0d game_over=%0b busy=%0b @%0d",
               en, ev.led, ev.score, ev.level, ev.misses, ev.game_over, ev.busy, ec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/whackamole_round_ctrl.md
# whackamole_round_ctrl

Game sequencer for the Whackamole board. It picks one mole LED at a time from a free-running LFSR and holds it for a level-dependent window. It detects switch toggles as hits or wrong whacks, and maintains score, level and miss count until game over. It runs on the main `clk` with a `tick` enable strobe instead of derived clocks, and drives the LED bank and the score/level inputs of the 7-segment display path.

## Interface
Parameters:
- LFSR_SEED, 8'hB8, non-zero reset value of the mole LFSR
- BASE_WINDOW, 16, mole-visible ticks at level 1
- GAP_TICKS, 4, ticks with all LEDs dark between moles
- LEVEL_STEP, 10, hits per level increment
- MAX_LEVEL, 7, level saturation value
- MAX_MISSES, 3, misses that end the game (range 1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-`clk`-wide timebase strobe (200 Hz on the board)
- start  in  1  debounced start request, level-sensitive, sampled each `clk`
- sw  in  8  player switches, already synchronised to `clk`
- led  out  8  mole mask, one-hot in SHOW, 0 otherwise
- score  out  8  hit count, saturates at 255
- level  out  3  current level, 1..MAX_LEVEL
- misses  out  2  miss count
- game_over  out  1  high in OVER
- busy  out  1  high in SHOW or GAP

## Operation
- Reset values: led=0, score=0, level=1, misses=0, game_over=0, busy=0, state IDLE, lfsr=LFSR_SEED, sw_q=sw, so no spurious edge is seen after reset.
- Edge detect: `sw_q <= sw` every cycle; edge = sw ^ sw_q. Either toggle direction counts. Edges are ignored outside SHOW.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every non-reset cycle. Mole index = lfsr[2:0], sampled when SHOW is entered, so led = 1 << idx. Repeats of the same mole are allowed.
- State IDLE: start=1 clears score, misses and pts_in_level, sets level=1, and goes to GAP.
- State GAP: led=0. A counter loads GAP_TICKS on entry and decrements on tick. On the tick that reaches 0 the state goes to SHOW, sampling the mole and loading window = BASE_WINDOW - 2*(level-1).
- State SHOW, checked in this priority order:
  - (1) Edge on the mole bit is a hit: score+1 (saturating), pts_in_level+1, then go to GAP. When pts_in_level reaches LEVEL_STEP it resets to 0 and level+1, saturating at MAX_LEVEL.
  - (2) Else an edge only on non-mole bits is a wrong whack: misses+1, the state stays SHOW and the window keeps running. Multiple wrong bits in one cycle count as one miss.
  - (3) Else a tick with window==1 is a timeout: misses+1, go to GAP.
  - A hit in the same cycle as a timeout counts as a hit. A wrong whack in the same cycle as a timeout counts as one miss.
- Any miss that brings misses to MAX_MISSES goes to OVER immediately, overriding the GAP/SHOW target.
- State OVER: led=0, game_over=1, and score/level/misses are held. start=1 behaves exactly as in IDLE.
- start is ignored in SHOW and GAP.
- rst mid-game returns all state and outputs to reset values on the next edge.

## Timing
- All outputs are registered. Hits, misses and state changes are visible one `clk` after the qualifying edge/tick cycle.
- Start to first mole: 1 cycle to GAP, then GAP_TICKS ticks, then led is valid the cycle after the final GAP tick.
- Window length is exactly window ticks. The timeout is taken on the window-th tick after SHOW entry, provided no hit occurs.
- The level increment takes effect at the next SHOW entry. The window is never recomputed mid-SHOW.
- Window minimum is 4 ticks at level 7 with defaults.

## Test plan
- Reset with sw=8'h5A held, then deassert: no miss, led=0, level=1, busy=0. Pulse start: after 4 ticks led is one-hot, busy=1.
- In SHOW, toggle the switch matching led: score=1, led=0 next cycle, state GAP. A new one-hot led appears after 4 ticks.
- In SHOW, toggle two non-mole switches in one cycle: misses=1, same led held. Then let 16 ticks elapse with no input: misses=2, led=0.
- Three timeouts in a row: game_over=1, busy=0, led=0, score unchanged. Pulse start: score=0, misses=0, game_over=0.
- Score 10 hits: level=2 and the next window is 14 ticks. Continue to 60 hits: level=7 with a 4-tick window, and level stays 7 at 70+ hits.
- Toggle the mole bit on the same cycle as the final window tick: counted as a hit, misses unchanged. Assert rst mid-SHOW: all outputs return to reset values on the next cycle.
